// File: rtl/n1_pkg.sv
// n1_pkg: shared constants and loader state encoding for the n1 core front end.
package n1_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CKSUM, DONE, ERR} state_e;
endpackage

// File: rtl/n1_prog_loader_if.sv
// n1_prog_loader_if: byte stream into the loader and program RAM write port out of it.
interface n1_prog_loader_if;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic wr_en;
    logic [n1_pkg::ADDR_W-1:0] wr_addr;
    logic [n1_pkg::DATA_W-1:0] wr_data;
    modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
    modport slave (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/n1_prog_loader.sv
// n1_prog_loader: assembles framed bytes into 16-bit words, writes them from address 0, then releases the core.
// Build option N1_LOADER_CKSUM_EN adds a trailing checksum byte and the CKSUM/ERR states.
module n1_prog_loader
    import n1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    n1_prog_loader_if.slave  bus,
    input  logic             start,
    output logic             core_run,
    output logic             busy,
    output logic             err,
    output logic [ADDR_W:0]  load_cnt
);
`ifdef N1_LOADER_CKSUM_EN
    localparam state_e LAST = CKSUM;
    logic [7:0] acc_q, acc_d;
    logic err_q;
`else
    localparam state_e LAST = DONE;
`endif
    state_e state_q, state_d;
    logic [7:0] hi_q, hi_d, b;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [ADDR_W:0] left_q, left_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d, in_ready_q, core_run_q, busy_q, xfer;
    assign b = bus.in_data;
    // a byte arriving together with start is dropped
    assign xfer = bus.in_valid & in_ready_q & ~start;
    always_comb begin
        state_d = state_q;
        hi_d = hi_q;
        addr_d = addr_q;
        left_d = left_q;
        cnt_d = cnt_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start) begin
            state_d = IDLE;
            addr_d = '0;
            cnt_d = '0;
        end else if (xfer) begin
            case (state_q)
                IDLE: state_d = (b == HDR_BYTE) ? COUNT : IDLE;
                COUNT: begin
                    left_d = {b == 8'd0, b};
                    state_d = HI;
                end
                HI: begin
                    hi_d = b;
                    state_d = LO;
                end
                LO: begin
                    wr_en_d = 1'b1;
                    wr_data_d = {hi_q, b};
                    wr_addr_d = addr_q;
                    addr_d = addr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    left_d = left_q - 1'b1;
                    state_d = (left_q == (ADDR_W+1)'(1)) ? LAST : HI;
                end
`ifdef N1_LOADER_CKSUM_EN
                CKSUM: state_d = (8'(acc_q + b) == 8'd0) ? DONE : ERR;
`endif
                default: ;
            endcase
        end
    end
`ifdef N1_LOADER_CKSUM_EN
    always_comb acc_d = !xfer ? acc_q : (state_q == COUNT) ? b : 8'(acc_q + b);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q <= '0;
            addr_q <= '0;
            left_q <= '0;
            cnt_q <= '0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            in_ready_q <= 1'b1;
            busy_q <= 1'b0;
            core_run_q <= 1'b0;
`ifdef N1_LOADER_CKSUM_EN
            acc_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q <= hi_d;
            addr_q <= addr_d;
            left_q <= left_d;
            cnt_q <= cnt_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            in_ready_q <= !(state_d inside {DONE, ERR});
            busy_q <= state_d inside {COUNT, HI, LO, CKSUM};
            core_run_q <= state_d == DONE;
`ifdef N1_LOADER_CKSUM_EN
            acc_q <= acc_d;
            err_q <= state_d == ERR;
`endif
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.wr_en = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign core_run = core_run_q;
    assign busy = busy_q;
    assign load_cnt = cnt_q;
endmodule

// File: tb/tb_n1_prog_loader.sv
// tb_n1_prog_loader: directed and randomized frames checked against a frame-level model of the loader.
// Follows N1_LOADER_CKSUM_EN so the same bench covers both builds.
module tb_n1_prog_loader;
    import n1_pkg::*;
`ifdef N1_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic core_run, busy, err;
    logic [ADDR_W:0] load_cnt;
    n1_prog_loader_if bus();
    n1_prog_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus), .start(start),
                        .core_run(core_run), .busy(busy), .err(err), .load_cnt(load_cnt));
    always #5 clk = ~clk;
    int checks = 0, errors = 0, ncyc = 0;
    int xq[$];
    int wq[$];
    logic [ADDR_W-1:0] waq[$];
    logic [DATA_W-1:0] wdq[$];
    // transfers and writes are logged at the falling edge, each with its cycle number
    always @(negedge clk) begin
        ncyc++;
        if (bus.in_valid && bus.in_ready && !start && rst_n) xq.push_back(ncyc);
        if (bus.wr_en) begin
            wq.push_back(ncyc);
            waq.push_back(bus.wr_addr);
            wdq.push_back(bus.wr_data);
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic clr();
        xq.delete();
        wq.delete();
        waq.delete();
        wdq.delete();
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask
    task automatic send(input logic [7:0] v, input int gap);
        int t = 0;
        bus.in_valid = 1'b0;
        tick(gap);
        while (!bus.in_ready) begin
            if (++t > 50) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout obs=0 exp=1");
                return;
            end
            tick(1);
        end
        bus.in_data = v;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
    endtask
    task automatic check_reset(input string t);
        check({t, "_in_ready"}, 32'(bus.in_ready), 1);
        check({t, "_wr_en"}, 32'(bus.wr_en), 0);
        check({t, "_wr_addr"}, 32'(bus.wr_addr), 0);
        check({t, "_wr_data"}, 32'(bus.wr_data), 0);
        check({t, "_core_run"}, 32'(core_run), 0);
        check({t, "_busy"}, 32'(busy), 0);
        check({t, "_err"}, 32'(err), 0);
        check({t, "_load_cnt"}, 32'(load_cnt), 0);
    endtask
    // gm: 0 = back-to-back, 1 = valid idles one cycle before every byte, 2 = random gaps
    task automatic run_frame(input string t, input logic [7:0] pre[$], input logic [15:0] w[$],
                             input int gm, input bit ok);
        logic [7:0] s[$];
        logic [7:0] sum, ck;
        int k;
        pulse_start();
        clr();
        s = pre;
        s.push_back(HDR_BYTE);
        s.push_back(8'(w.size()));
        sum = 8'(w.size());
        foreach (w[i]) begin
            s.push_back(w[i][15:8]);
            s.push_back(w[i][7:0]);
            sum = sum + w[i][15:8] + w[i][7:0];
        end
        ck = 8'd0 - sum;
        if (CK) s.push_back(ok ? ck : ck ^ 8'h5A);
        foreach (s[i]) send(s[i], gm == 0 ? 0 : gm == 1 ? 1 : int'($urandom_range(0, 3)));
        tick(3);
        check({t, "_nwr"}, wq.size(), w.size());
        for (int i = 0; i < wq.size() && i < w.size(); i++) begin
            k = pre.size() + 3 + 2 * i;
            check({t, "_addr"}, 32'(waq[i]), i);
            check({t, "_data"}, 32'(wdq[i]), 32'(w[i]));
            check({t, "_lat"}, k < xq.size() ? wq[i] - xq[k] : -1, 1);
        end
        check({t, "_core_run"}, 32'(core_run), 32'(!CK || ok));
        check({t, "_err"}, 32'(err), 32'(CK && !ok));
        check({t, "_busy"}, 32'(busy), 0);
        check({t, "_in_ready"}, 32'(bus.in_ready), 0);
        check({t, "_load_cnt"}, 32'(load_cnt), w.size());
    endtask
    initial begin
        logic [7:0] none[$];
        logic [7:0] junk[$];
        logic [15:0] w[$];
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        tick(1);
        w = '{16'h0001};
        run_frame("one_word", none, w, 0, 1'b1);
        w = '{16'h1234, 16'hABCD};
        run_frame("bad_cksum", none, w, 0, 1'b0);
        pulse_start();
        check("start_err", 32'(err), 0);
        check("start_core_run", 32'(core_run), 0);
        check("start_in_ready", 32'(bus.in_ready), 1);
        check("start_load_cnt", 32'(load_cnt), 0);
        junk = '{8'h00, 8'hFF, 8'h5A};
        w = '{16'h0001};
        run_frame("garbage", junk, w, 0, 1'b1);
        w.delete();
        repeat (256) w.push_back(16'($urandom));
        run_frame("full256", none, w, 2, 1'b1);
        w.delete();
        repeat (9) w.push_back(16'($urandom));
        run_frame("nogap", none, w, 0, 1'b1);
        run_frame("gap", none, w, 1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            w.delete();
            repeat ($urandom_range(1, 24)) w.push_back(16'($urandom));
            run_frame("rand", none, w, 2, 1'($urandom_range(0, 1)));
        end
        pulse_start();
        clr();
        foreach (junk[i]) junk[i] = 8'h00;
        junk = '{HDR_BYTE, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (junk[i]) send(junk[i], 0);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        check("rst_mid_wr_before", wq.size(), 2);
        @(posedge clk);
        #1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_mid_nowr", wq.size(), 2);
        check("rst_mid_busy", 32'(busy), 0);
        pulse_start();
        clr();
        bus.in_data = HDR_BYTE;
        bus.in_valid = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        bus.in_valid = 1'b0;
        tick(1);
        check("start_drop_busy", 32'(busy), 0);
        send(8'h03, 0);
        tick(1);
        check("start_drop_idle", 32'(busy), 0);
        junk = '{HDR_BYTE, 8'h02, 8'h11, 8'h22, 8'h33};
        foreach (junk[i]) send(junk[i], 0);
        bus.in_data = 8'h44;
        bus.in_valid = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        bus.in_valid = 1'b0;
        tick(2);
        check("abort_busy", 32'(busy), 0);
        check("abort_load_cnt", 32'(load_cnt), 0);
        check("abort_core_run", 32'(core_run), 0);
        check("abort_in_ready", 32'(bus.in_ready), 1);
        check("abort_nwr", wq.size(), 1);
        w = '{16'hBEEF, 16'h0F0F, 16'h8001};
        run_frame("after_abort", none, w, 1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
